// File: rtl/input_controller_pkg.sv
// Shared button codes, button bit positions and poll FSM states for the
// pad input controller and the grid controller that consumes its codes.
package input_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_CLK_HI = 3'd2,
    ST_CLK_LO = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [3:0] BTN_AIR    = 4'b0000;
  localparam logic [3:0] BTN_A      = 4'b0001;
  localparam logic [3:0] BTN_B      = 4'b0010;
  localparam logic [3:0] BTN_SELECT = 4'b0011;
  localparam logic [3:0] BTN_START  = 4'b0100;
  localparam logic [3:0] BTN_UP     = 4'b0101;
  localparam logic [3:0] BTN_DOWN   = 4'b0110;
  localparam logic [3:0] BTN_LEFT   = 4'b0111;
  localparam logic [3:0] BTN_RIGHT  = 4'b1000;

  localparam int BIT_A      = 0;
  localparam int BIT_B      = 1;
  localparam int BIT_SELECT = 2;
  localparam int BIT_START  = 3;
  localparam int BIT_UP     = 4;
  localparam int BIT_DOWN   = 5;
  localparam int BIT_LEFT   = 6;
  localparam int BIT_RIGHT  = 7;

endpackage

// File: rtl/input_controller_button_encoder.sv
// Combinational priority encoder from the pressed-button byte to the
// 4-bit code understood by the grid controller.
module input_controller_button_encoder
  import input_controller_pkg::*;
(
  input  logic [7:0] buttons,
  output logic [3:0] code
);

  // Start outranks movement; Left deliberately wins over Right.
  always_comb begin
    code = BTN_AIR;
    if (buttons[BIT_START])       code = BTN_START;
    else if (buttons[BIT_LEFT])   code = BTN_LEFT;
    else if (buttons[BIT_RIGHT])  code = BTN_RIGHT;
    else if (buttons[BIT_DOWN])   code = BTN_DOWN;
    else if (buttons[BIT_UP])     code = BTN_UP;
    else if (buttons[BIT_A])      code = BTN_A;
    else if (buttons[BIT_B])      code = BTN_B;
    else if (buttons[BIT_SELECT]) code = BTN_SELECT;
  end

endmodule

// File: rtl/input_controller.sv
// NES pad poller: periodically latches and shifts in the 8 buttons,
// debounces over two identical frames and publishes an encoded button code.
module input_controller
  import input_controller_pkg::*;
#(
  parameter int CLK_DIV       = 300,
  parameter int POLL_INTERVAL = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic [3:0] controller_out,
  output logic       frame_done
);

  localparam int POLL_W  = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int PHASE_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_INTERVAL - 1);
  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * CLK_DIV - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(CLK_DIV - 1);

  state_e             state_q, state_d;
  logic [POLL_W-1:0]  poll_q, poll_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [2:0]         index_q, index_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         prev_q, prev_d;
  logic [7:0]         buttons_q, buttons_d;
  logic [3:0]         code_q, code_d;
  logic               nes_latch_q, nes_latch_d;
  logic               nes_clk_q, nes_clk_d;
  logic               frame_done_q, frame_done_d;
  logic [3:0]         enc_code;

  input_controller_button_encoder u_encoder (
    .buttons (shift_q),
    .code    (enc_code)
  );

  // The poll counter never stops, so frame starts stay on a fixed grid.
  always_comb begin
    state_d   = state_q;
    poll_d    = (poll_q == POLL_LAST) ? '0 : poll_q + 1'b1;
    phase_d   = phase_q;
    index_d   = index_q;
    shift_d   = shift_q;
    prev_d    = prev_q;
    buttons_d = buttons_q;
    code_d    = code_q;

    case (state_q)
      ST_IDLE: begin
        if (poll_q == POLL_LAST) begin
          state_d = ST_LATCH;
          phase_d = '0;
        end
      end
      ST_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          shift_d[0] = ~nes_data;
          index_d    = 3'd1;
          phase_d    = '0;
          state_d    = ST_CLK_HI;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_CLK_HI: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          state_d = ST_CLK_LO;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_CLK_LO: begin
        if (phase_q == HALF_LAST) begin
          shift_d[index_q] = ~nes_data;
          phase_d          = '0;
          if (index_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + 3'd1;
            state_d = ST_CLK_HI;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_DONE: begin
        // Commit only when this frame matches the previous raw frame.
        if (shift_q == prev_q) begin
          buttons_d = shift_q;
          code_d    = enc_code;
        end
        prev_d  = shift_q;
        index_d = 3'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    nes_latch_d  = (state_d == ST_LATCH);
    nes_clk_d    = (state_d == ST_CLK_HI);
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      poll_q       <= '0;
      phase_q      <= '0;
      index_q      <= '0;
      shift_q      <= '0;
      prev_q       <= '0;
      buttons_q    <= '0;
      code_q       <= BTN_AIR;
      nes_latch_q  <= 1'b0;
      nes_clk_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      poll_q       <= poll_d;
      phase_q      <= phase_d;
      index_q      <= index_d;
      shift_q      <= shift_d;
      prev_q       <= prev_d;
      buttons_q    <= buttons_d;
      code_q       <= code_d;
      nes_latch_q  <= nes_latch_d;
      nes_clk_q    <= nes_clk_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nes_latch      = nes_latch_q;
  assign nes_clk        = nes_clk_q;
  assign buttons        = buttons_q;
  assign controller_out = code_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_input_controller.sv
// Bench for input_controller: a behavioural NES pad drives nes_data, and a
// frame-level reference model predicts the debounced buttons and code.
module tb_input_controller;

  localparam int CLK_DIV       = 2;
  localparam int POLL_INTERVAL = 40;

  logic       clk;
  logic       reset;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic [3:0] controller_out;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pressed = 8'h00;
  logic [7:0] snap    = 8'h00;
  int         ptr     = 0;
  logic       clk_prev = 1'b0;

  logic [7:0] model_prev;
  logic [7:0] model_buttons;
  logic [3:0] model_code;

  input_controller #(
    .CLK_DIV       (CLK_DIV),
    .POLL_INTERVAL (POLL_INTERVAL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .nes_data       (nes_data),
    .nes_latch      (nes_latch),
    .nes_clk        (nes_clk),
    .buttons        (buttons),
    .controller_out (controller_out),
    .frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad behaves like a 4021 shift register: load on latch, advance on nes_clk rise.
  initial nes_data = 1'b1;
  always @(negedge clk) begin
    if (nes_latch) begin
      snap = pressed;
      ptr  = 0;
    end else if (nes_clk && !clk_prev) begin
      ptr = ptr + 1;
    end
    clk_prev = nes_clk;
    nes_data = (ptr < 8) ? ~snap[ptr[2:0]] : 1'b1;
  end

  function automatic logic [3:0] ref_code(input logic [7:0] b);
    int order [8] = '{3, 6, 7, 5, 4, 0, 1, 2};
    int codes [8] = '{4, 7, 8, 6, 5, 1, 2, 3};
    for (int i = 0; i < 8; i++)
      if (b[order[i]]) return 4'(codes[i]);
    return 4'd0;
  endfunction

  task automatic model_reset();
    model_prev    = 8'h00;
    model_buttons = 8'h00;
    model_code    = 4'h0;
  endtask

  task automatic model_frame(input logic [7:0] raw);
    if (raw == model_prev) begin
      model_buttons = raw;
      model_code    = ref_code(raw);
    end
    model_prev = raw;
  endtask

  // Runs one poll frame with the given pad state; returns at the first cycle the commit is visible.
  task automatic run_frame(input logic [7:0] pad, output bit ok);
    int n;
    pressed = pad;
    ok = 1'b0;
    n = 0;
    while (n < 100 && !ok) begin
      @(negedge clk);
      n++;
      if (frame_done) ok = 1'b1;
    end
    @(negedge clk);
    model_frame(pad);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bit seen_active;
    @(negedge clk);
    reset = 1'b0;
    seen_active = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (nes_latch || nes_clk || frame_done) seen_active = 1'b1;
    end
    n_checks++;
    if ({nes_latch, nes_clk, buttons, controller_out, frame_done} !== 15'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got latch=%b clk=%b buttons=%h code=%h done=%b, required all zero",
               nes_latch, nes_clk, buttons, controller_out, frame_done);
    end
    n_checks++;
    if (seen_active !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_quiet: got activity=%b, required 0", seen_active);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_idle_pad();
    int n, latch_cyc, pulses, hi_cyc, done_at, overlap;
    bit prev_clk;
    pressed = 8'h00;
    n = 0;
    while (n < 100 && !nes_latch) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== POLL_INTERVAL) begin
      n_fail++;
      $display("[TB] FAIL first_latch_delay: got %0d cycles, required %0d", n, POLL_INTERVAL);
    end
    latch_cyc = 0; pulses = 0; hi_cyc = 0; done_at = 0; overlap = 0; prev_clk = 1'b0;
    for (int t = 1; t <= 38; t++) begin
      if (nes_latch) latch_cyc++;
      if (nes_clk) hi_cyc++;
      if (nes_clk && !prev_clk) pulses++;
      if (nes_clk && nes_latch) overlap++;
      if (frame_done && done_at == 0) done_at = t;
      prev_clk = nes_clk;
      @(negedge clk);
    end
    model_frame(8'h00);
    n_checks++;
    if (latch_cyc !== 2 * CLK_DIV) begin
      n_fail++;
      $display("[TB] FAIL latch_width: got %0d, required %0d", latch_cyc, 2 * CLK_DIV);
    end
    n_checks++;
    if (pulses !== 7 || hi_cyc !== 7 * CLK_DIV) begin
      n_fail++;
      $display("[TB] FAIL clk_pulses: got %0d pulses / %0d high cycles, required 7 / %0d",
               pulses, hi_cyc, 7 * CLK_DIV);
    end
    n_checks++;
    if (done_at !== 16 * CLK_DIV + 1) begin
      n_fail++;
      $display("[TB] FAIL frame_done_cycle: got %0d, required %0d", done_at, 16 * CLK_DIV + 1);
    end
    n_checks++;
    if (overlap !== 0 || controller_out !== 4'h0) begin
      n_fail++;
      $display("[TB] FAIL idle_frame: got overlap=%0d code=%h, required 0 and 0", overlap, controller_out);
    end
  endtask

  task automatic test_right_two_frames();
    bit ok;
    run_frame(8'h80, ok);
    n_checks++;
    if (!ok || controller_out !== 4'h0) begin
      n_fail++;
      $display("[TB] FAIL right_frame1: got done=%b code=%h, required 1 and 0", ok, controller_out);
    end
    run_frame(8'h80, ok);
    n_checks++;
    if (!ok || controller_out !== 4'h8 || buttons !== 8'h80) begin
      n_fail++;
      $display("[TB] FAIL right_frame2: got done=%b code=%h buttons=%h, required 1, 8, 80",
               ok, controller_out, buttons);
    end
  endtask

  task automatic test_alternating();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      run_frame((i % 2 == 0) ? 8'h08 : 8'h80, ok);
      n_checks++;
      if (!ok || controller_out !== 4'h8 || buttons !== 8'h80 || controller_out !== model_code) begin
        n_fail++;
        $display("[TB] FAIL alternate_hold[%0d]: got done=%b code=%h buttons=%h, required 1, 8, 80",
                 i, ok, controller_out, buttons);
      end
    end
  endtask

  task automatic test_combo();
    bit ok;
    run_frame(8'hC1, ok);
    run_frame(8'hC1, ok);
    n_checks++;
    if (!ok || controller_out !== 4'h7 || buttons !== 8'hC1) begin
      n_fail++;
      $display("[TB] FAIL left_right_a: got code=%h buttons=%h, required 7 and c1", controller_out, buttons);
    end
    run_frame(8'hC9, ok);
    run_frame(8'hC9, ok);
    n_checks++;
    if (!ok || controller_out !== 4'h4 || buttons !== 8'hC9) begin
      n_fail++;
      $display("[TB] FAIL with_start: got code=%h buttons=%h, required 4 and c9", controller_out, buttons);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] raw, last;
    last = model_prev;
    for (int i = 0; i < 16; i++) begin
      raw = ($urandom_range(0, 1) == 1) ? last : 8'($urandom);
      run_frame(raw, ok);
      last = raw;
      n_checks++;
      if (!ok || buttons !== model_buttons || controller_out !== model_code) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: raw=%h got buttons=%h code=%h, required %h %h",
                 i, raw, buttons, controller_out, model_buttons, model_code);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok, got_done;
    int n, pulses;
    bit prev_clk;
    run_frame(8'h80, ok);
    run_frame(8'h80, ok);
    pressed = 8'h80;
    pulses = 0; prev_clk = 1'b0; n = 0;
    while (n < 100 && pulses < 4) begin
      @(negedge clk);
      n++;
      if (nes_clk && !prev_clk) pulses++;
      prev_clk = nes_clk;
    end
    n_checks++;
    if (pulses !== 4 || buttons !== 8'h80) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_setup: got pulses=%0d buttons=%h, required 4 and 80", pulses, buttons);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({nes_latch, nes_clk, buttons, controller_out, frame_done} !== 15'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_outputs: got latch=%b clk=%b buttons=%h code=%h done=%b, required all zero",
               nes_latch, nes_clk, buttons, controller_out, frame_done);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    got_done = 1'b0; n = 0;
    while (n < 100 && !nes_latch) begin
      @(negedge clk);
      n++;
      if (frame_done) got_done = 1'b1;
    end
    n_checks++;
    if (n !== POLL_INTERVAL || got_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_restart: got latch after %0d cycles, done=%b, required %0d and 0",
               n, got_done, POLL_INTERVAL);
    end
    run_frame(8'h80, ok);
    n_checks++;
    if (!ok || buttons !== model_buttons || controller_out !== model_code) begin
      n_fail++;
      $display("[TB] FAIL post_reset_frame: got buttons=%h code=%h, required %h %h",
               buttons, controller_out, model_buttons, model_code);
    end
  endtask

  task automatic test_protocol();
    int rises, last_rise, overlap, cyc;
    bit prev_latch;
    rises = 0; last_rise = 0; overlap = 0; cyc = 0; prev_latch = nes_latch;
    while (cyc < 600 && rises < 11) begin
      @(negedge clk);
      cyc++;
      if (nes_latch && nes_clk) overlap++;
      if (nes_latch && !prev_latch) begin
        if (rises > 0) begin
          n_checks++;
          if (cyc - last_rise !== POLL_INTERVAL) begin
            n_fail++;
            $display("[TB] FAIL frame_spacing: got %0d, required %0d", cyc - last_rise, POLL_INTERVAL);
          end
        end
        rises++;
        last_rise = cyc;
        pressed = 8'($urandom);
      end
      prev_latch = nes_latch;
    end
    n_checks++;
    if (rises !== 11 || overlap !== 0) begin
      n_fail++;
      $display("[TB] FAIL protocol: got %0d frame starts, %0d overlaps, required 11 and 0", rises, overlap);
    end
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    test_reset();
    test_idle_pad();
    test_right_two_frames();
    test_alternating();
    test_combo();
    test_random();
    test_mid_reset();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_controller.md
INPUT_CONTROLLER -- requirements
Module: Input_Controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 300, meaning clk cycles per nes_clk half-period and half the latch width (6 us at 50 MHz).
REQ-002 SHALL have parameter POLL_INTERVAL, default 833333, meaning clk cycles between poll-frame starts (60 Hz at 50 MHz); legal only if POLL_INTERVAL > 16*CLK_DIV+2.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port: clk  input  1  system clock; all logic is on the rising edge.
REQ-005 Port: reset  input  1  synchronous, active-low reset.
REQ-006 Port: nes_data  input  1  serial button data from the pad; active-low, meaning 0 = pressed.
REQ-007 Port: nes_latch  output  1  parallel-load strobe to the pad.
REQ-008 Port: nes_clk  output  1  shift clock to the pad.
REQ-009 Port: buttons  output  8  last debounced raw state; 1 = pressed; bit order A,B,Select,Start,Up,Down,Left,Right is bit0..bit7.
REQ-010 Port: controller_out  output  4  encoded button code consumed by the grid controller.
REQ-011 Port: frame_done  output  1  one-cycle pulse at the end of every poll frame.

Function
REQ-012 SHALL run an FSM with states IDLE, LATCH, CLK_HI, CLK_LO and DONE.
REQ-013 IDLE: a free-running poll counter that wraps at POLL_INTERVAL-1; on wrap, go to LATCH.
REQ-014 LATCH: nes_latch=1 for exactly 2*CLK_DIV cycles; on its last cycle, sample ~nes_data into shift bit0 and set bit index=1.
REQ-015 CLK_HI: nes_clk=1 for CLK_DIV cycles, then go to CLK_LO.
REQ-016 CLK_LO: nes_clk=0 for CLK_DIV cycles; on its last cycle, sample ~nes_data into shift[index].
REQ-017 CLK_LO exit: if index==7 go to DONE; otherwise increment index and go to CLK_HI.
REQ-018 Frame length: a frame from the first LATCH cycle to DONE SHALL be exactly 16*CLK_DIV cycles plus 1 cycle in DONE.
REQ-019 DONE: lasts one cycle; frame_done=1; then return to IDLE.
REQ-020 Poll timing: the poll counter keeps running during a frame, so frame starts are exactly POLL_INTERVAL cycles apart.
REQ-021 Debounce: the shift register result SHALL be committed to buttons only when it equals the previous frame's raw result, meaning 2 consecutive identical frames.
REQ-022 Commit timing: buttons and controller_out SHALL update in the DONE cycle and become visible the next cycle.
REQ-023 Encoding: controller_out = 0000 when no button is pressed.
REQ-024 Encoding by priority, highest first: Start=0100, Left=0111, Right=1000, Down=0110, Up=0101, A=0001, B=0010, Select=0011.
REQ-025 Left+Right pressed together SHALL encode 0111 (Left wins).
REQ-026 controller_out SHALL hold its value between commits; it is a level signal, not a pulse.
REQ-027 nes_latch and nes_clk SHALL be registered outputs, glitch-free, and never high in the same cycle.
REQ-028 Outside LATCH, nes_latch=0; outside CLK_HI, nes_clk=0.

Reset
REQ-029 While reset==0, the outputs SHALL be: nes_latch=0, nes_clk=0, buttons=0, controller_out=0000, frame_done=0.
REQ-030 While reset==0, internal state SHALL be: state=IDLE, poll counter=0, phase counter=0, index=0, shift and previous-frame registers=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no commit; the first LATCH after release starts POLL_INTERVAL cycles after release.

Structure
REQ-032 A shared package SHALL hold the button code constants (AIR/none, A, B, SELECT, START, UP, DOWN, LEFT, RIGHT) and the FSM state encodings; the grid controller uses the same START/LEFT/RIGHT codes.
REQ-033 SHALL contain one sub-module, Button_Encoder: combinational 8-bit to 4-bit priority encoder.
REQ-034 All other logic SHALL stay in Input_Controller.

Verification (CLK_DIV=2, POLL_INTERVAL=40)
REQ-035 Idle pad (nes_data=1 always) -> nes_latch high 4 cycles, 7 nes_clk pulses of 2 cycles high each, frame_done at cycle 33 of the frame, controller_out stays 0000.
REQ-036 Pad model reports Right only for 2 frames -> after frame 1, controller_out=0000; after frame 2, controller_out=1000 and buttons=8'h80.
REQ-037 Right then Start on alternating frames -> no commit ever occurs; controller_out holds its prior value.
REQ-038 Left+Right+A held -> controller_out=0111 and buttons=8'hC1; with Start added -> controller_out=0100.
REQ-039 reset=0 asserted during CLK_HI of bit 4, then released -> outputs are zero the next cycle; no frame_done; the next nes_latch rises 40 cycles after release.
REQ-040 Protocol monitor across 10 frames -> nes_latch and nes_clk are never high together; frame starts are spaced exactly 40 cycles.
